// File: rtl/p88_load_arbiter.sv
// p88_load_arbiter: shares the system RAM port between the HPS P88 download
// stream and the Konix system bus. During a load each ioctl byte is buffered
// and the HPS is back-pressured. The system is held in reset for the whole
// load and for HOLD_CYCLES after the last buffered byte is written.
module p88_load_arbiter #(
    parameter int unsigned       ADDR_W      = 20,
    parameter logic [5:0]        LOAD_INDEX  = 6'd4,
    parameter logic [ADDR_W-1:0] LOAD_BASE   = '0,
    parameter int unsigned       HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [15:0]       ioctl_index,
    input  logic              ioctl_wr,
    input  logic [26:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              sys_hold,
    output logic              load_done
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        CPU_ACC,
        LD_ACC,
        CPU_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              load_active;
    logic              buf_full;
    logic [7:0]        buf_data;
    logic [ADDR_W-1:0] buf_addr;
    logic              last_ld;
    logic              grant_cpu;
    logic              grant_ld;
    logic              ld_ack;
    logic              buf_empty_nxt;
    logic              counting;
    logic [CNT_W-1:0]  hold_cnt;

    // Upper index/address bits are outside the decode and the RAM space.
    logic              unused_bits;
    assign unused_bits = &{1'b0, ioctl_index[15:6], ioctl_addr[26:ADDR_W]};

    assign load_active   = ioctl_download && (ioctl_index[5:0] == LOAD_INDEX);
    assign ld_ack        = (state == LD_ACC) && mem_ack;
    assign buf_empty_nxt = !buf_full || ld_ack;

    // All handshake outputs decode from registers only.
    assign mem_req    = (state == CPU_ACC) || (state == LD_ACC);
    assign cpu_ack    = (state == CPU_DONE);
    assign ioctl_wait = buf_full;

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and round-robin grant decision.
    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_ld  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req && buf_full) begin
                    if (last_ld) begin
                        grant_cpu = 1'b1;
                    end else begin
                        grant_ld = 1'b1;
                    end
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                end else if (buf_full) begin
                    grant_ld = 1'b1;
                end
                if (grant_cpu) begin
                    state_nxt = CPU_ACC;
                end else if (grant_ld) begin
                    state_nxt = LD_ACC;
                end
            end
            CPU_ACC: begin
                if (mem_ack) begin
                    state_nxt = CPU_DONE;
                end
            end
            LD_ACC: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            CPU_DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RAM request fields latched at grant; read data captured on CPU ack.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last_ld   <= 1'b0;
            cpu_din   <= '0;
        end else begin
            if (grant_cpu) begin
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_dout;
                last_ld   <= 1'b0;
            end else if (grant_ld) begin
                mem_we    <= 1'b1;
                mem_addr  <= buf_addr;
                mem_wdata <= buf_data;
                last_ld   <= 1'b1;
            end
            if ((state == CPU_ACC) && mem_ack) begin
                cpu_din <= mem_rdata;
            end
        end
    end

    // One-byte load buffer; strobes arriving while full are dropped.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            buf_addr <= '0;
        end else begin
            if (ld_ack) begin
                buf_full <= 1'b0;
            end else if (ioctl_wr && load_active && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= ioctl_dout;
                buf_addr <= ioctl_addr[ADDR_W-1:0] + LOAD_BASE;
            end
        end
    end

    // System hold: set while loading, released HOLD_CYCLES after the buffer drains.
    // The count starts on the edge the final write is acknowledged, so the
    // release lands exactly HOLD_CYCLES edges after that acknowledge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sys_hold  <= 1'b0;
            load_done <= 1'b0;
            counting  <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            load_done <= 1'b0;
            if (load_active) begin
                sys_hold <= 1'b1;
                counting <= 1'b0;
            end else if (counting) begin
                hold_cnt <= hold_cnt - 1'b1;
                if (hold_cnt == CNT_W'(1)) begin
                    sys_hold  <= 1'b0;
                    load_done <= 1'b1;
                    counting  <= 1'b0;
                end
            end else if (sys_hold && buf_empty_nxt) begin
                counting <= 1'b1;
                hold_cnt <= CNT_W'(HOLD_CYCLES);
            end
        end
    end

endmodule
